// File: rtl/macro_sequencer_if.sv
// Fetch-side, decode-side and interrupt signals of the macro sequencer.
// The sequencer itself uses the slave modport; the surrounding pipeline
// (or a bench) drives the master side.
interface macro_sequencer_if;
    logic       f_valid;
    logic [6:0] f_opcode;
    logic       f_ready;
    logic       int_req;
    logic       int_ack;
    logic       d_valid;
    logic [6:0] d_opcode;
    logic [1:0] d_uop;
    logic       d_last;
    logic       d_ready;
    logic       halted;

    modport master (
        output f_valid, f_opcode, int_req, d_ready,
        input  f_ready, int_ack, d_valid, d_opcode, d_uop, d_last, halted
    );

    modport slave (
        input  f_valid, f_opcode, int_req, d_ready,
        output f_ready, int_ack, d_valid, d_opcode, d_uop, d_last, halted
    );
endinterface

// File: rtl/macro_sequencer.sv
// Macro-instruction sequencer: passes plain opcodes through a one-entry
// registered slot and expands CALL/RET/INT/RTI into PUSH/POP/JMP/NOP
// micro-op sequences; turns external interrupts into INT sequences and
// parks the front end on HLT.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   PASS  | plain pass-through; accepts fetch or starts a pending INT
//   SEQ   | emitting steps of a CALL/RET/INT/RTI sequence, fetch blocked
//   HALT  | parked after HLT; only a pending interrupt (or reset) exits
module macro_sequencer #(
    parameter int RET_BUBBLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    macro_sequencer_if.slave bus
);

    typedef enum logic [1:0] {ST_PASS = 2'd0, ST_SEQ = 2'd1, ST_HALT = 2'd2} state_t;
    typedef enum logic [1:0] {K_CALL = 2'd0, K_RET = 2'd1, K_INT = 2'd2, K_RTI = 2'd3} kind_t;

    localparam logic [6:0] OP_PUSH   = 7'b1000000;
    localparam logic [6:0] OP_POP    = 7'b1001000;
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [4:0] OP_JMP_HI = 5'b11011;
    localparam logic [2:0] BUBBLES   = 3'(RET_BUBBLES);

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [2:0] step_q, step_d;
    logic [1:0] ab_q, ab_d;
    logic       int_pend_q, int_pend_d;
    logic       d_valid_q, d_valid_d;
    logic [6:0] d_opcode_q, d_opcode_d;
    logic [1:0] d_uop_q, d_uop_d;
    logic       d_last_q, d_last_d;
    logic       int_ack_q, int_ack_d;

    logic       slot_free;
    logic       f_ready;
    logic       start_int;
    logic       is_macro;
    logic       is_hlt;
    kind_t      sel_kind;
    logic [2:0] sel_step;
    logic [1:0] sel_ab;
    logic [6:0] seq_op;
    logic [1:0] seq_uop;
    logic       seq_last;

    assign slot_free = !d_valid_q || bus.d_ready;
    assign f_ready   = (state_q == ST_PASS) && slot_free && !int_pend_q;
    // Interrupts are only taken at an instruction boundary (PASS) or from HALT.
    assign start_int = (state_q != ST_SEQ) && slot_free && int_pend_q;
    assign is_macro  = (bus.f_opcode[6:4] == 3'b111);
    assign is_hlt    = (bus.f_opcode[6:2] == 5'b00001);

    // Select which sequence and step feed the micro-op table this cycle:
    // the running one in SEQ, otherwise step 0 of whatever is being started.
    always_comb begin
        sel_kind = kind_q;
        sel_step = step_q;
        sel_ab   = ab_q;
        if (state_q != ST_SEQ) begin
            sel_step = 3'd0;
            if (start_int) begin
                sel_kind = K_INT;
                sel_ab   = 2'b00;
            end else begin
                sel_kind = kind_t'(bus.f_opcode[3:2]);
                sel_ab   = bus.f_opcode[1:0];
            end
        end
    end

    // Micro-op table: opcode, operand tag and end-of-sequence flag per step.
    always_comb begin
        seq_op   = OP_NOP;
        seq_uop  = 2'b00;
        seq_last = 1'b0;
        case (sel_kind)
            K_CALL: begin
                if (sel_step == 3'd0) begin
                    seq_op  = OP_PUSH;
                    seq_uop = 2'b01;
                end else begin
                    seq_op   = {OP_JMP_HI, sel_ab};
                    seq_last = 1'b1;
                end
            end
            K_INT: begin
                if (sel_step == 3'd0) begin
                    seq_op  = OP_PUSH;
                    seq_uop = 2'b01;
                end else if (sel_step == 3'd1) begin
                    seq_op  = OP_PUSH;
                    seq_uop = 2'b10;
                end else begin
                    seq_op   = {OP_JMP_HI, sel_ab};
                    seq_uop  = 2'b11;
                    seq_last = 1'b1;
                end
            end
            K_RET: begin
                if (sel_step == 3'd0) begin
                    seq_op  = OP_POP;
                    seq_uop = 2'b01;
                end
                seq_last = (sel_step == BUBBLES);
            end
            default: begin
                if (sel_step == 3'd0) begin
                    seq_op  = OP_POP;
                    seq_uop = 2'b10;
                end else if (sel_step == 3'd1) begin
                    seq_op  = OP_POP;
                    seq_uop = 2'b01;
                end
                seq_last = (sel_step == BUBBLES + 3'd1);
            end
        endcase
    end

    // Next-state, slot load and interrupt bookkeeping.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        step_d     = step_q;
        ab_d       = ab_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_uop_d    = d_uop_q;
        d_last_d   = d_last_q;
        int_ack_d  = 1'b0;
        int_pend_d = int_pend_q || bus.int_req;

        // A free slot with nothing new to load empties.
        if (slot_free) begin
            d_valid_d = 1'b0;
        end

        case (state_q)
            ST_PASS, ST_HALT: begin
                if (start_int || (bus.f_valid && f_ready && is_macro)) begin
                    d_valid_d  = 1'b1;
                    d_opcode_d = seq_op;
                    d_uop_d    = seq_uop;
                    d_last_d   = seq_last;
                    kind_d     = sel_kind;
                    ab_d       = sel_ab;
                    state_d    = seq_last ? ST_PASS : ST_SEQ;
                    step_d     = seq_last ? 3'd0 : 3'd1;
                    if (start_int) begin
                        int_ack_d  = 1'b1;
                        // A request arriving on the start edge is kept as a new one.
                        int_pend_d = bus.int_req;
                    end
                end else if (bus.f_valid && f_ready) begin
                    d_valid_d  = 1'b1;
                    d_opcode_d = bus.f_opcode;
                    d_uop_d    = 2'b00;
                    d_last_d   = 1'b1;
                    if (is_hlt) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_SEQ: begin
                if (slot_free) begin
                    d_valid_d  = 1'b1;
                    d_opcode_d = seq_op;
                    d_uop_d    = seq_uop;
                    d_last_d   = seq_last;
                    state_d    = seq_last ? ST_PASS : ST_SEQ;
                    step_d     = seq_last ? 3'd0 : step_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_PASS;
                step_d  = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            kind_q     <= K_CALL;
            step_q     <= 3'd0;
            ab_q       <= 2'b00;
            int_pend_q <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= 7'b0000000;
            d_uop_q    <= 2'b00;
            d_last_q   <= 1'b0;
            int_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            step_q     <= step_d;
            ab_q       <= ab_d;
            int_pend_q <= int_pend_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_uop_q    <= d_uop_d;
            d_last_q   <= d_last_d;
            int_ack_q  <= int_ack_d;
        end
    end

    assign bus.f_ready  = f_ready;
    assign bus.d_valid  = d_valid_q;
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_uop    = d_uop_q;
    assign bus.d_last   = d_last_q;
    assign bus.int_ack  = int_ack_q;
    assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_macro_sequencer.sv
// Bench for macro_sequencer: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_macro_sequencer;

    localparam int B = 1;

    localparam logic [6:0] PUSH = 7'b1000000;
    localparam logic [6:0] POP  = 7'b1001000;
    localparam logic [6:0] NOP  = 7'b0000000;
    localparam logic [6:0] ADD  = 7'b0100000;
    localparam logic [6:0] SUB  = 7'b0100001;
    localparam logic [6:0] HLT  = 7'b0000100;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    macro_sequencer_if bus ();

    macro_sequencer #(.RET_BUBBLES(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0] op;
        logic [1:0] uop;
        logic       last;
    } uop_t;

    uop_t       pend[$];
    logic       m_v;
    logic [6:0] m_op;
    logic [1:0] m_uop;
    logic       m_last;
    logic       m_ack;
    logic       m_halted;
    logic       m_ipend;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_uop(input logic [6:0] op, input logic [1:0] u);
        uop_t e;
        e.op   = op;
        e.uop  = u;
        e.last = 1'b0;
        pend.push_back(e);
    endfunction

    // Full micro-op list of a macro instruction; the final entry ends it.
    function automatic void expand(input logic [1:0] kind, input logic [1:0] ab);
        case (kind)
            2'b00: begin
                push_uop(PUSH, 2'b01);
                push_uop({5'b11011, ab}, 2'b00);
            end
            2'b10: begin
                push_uop(PUSH, 2'b01);
                push_uop(PUSH, 2'b10);
                push_uop({5'b11011, ab}, 2'b11);
            end
            2'b01: begin
                push_uop(POP, 2'b01);
                for (int i = 0; i < B; i++) push_uop(NOP, 2'b00);
            end
            default: begin
                push_uop(POP, 2'b10);
                push_uop(POP, 2'b01);
                for (int i = 0; i < B; i++) push_uop(NOP, 2'b00);
            end
        endcase
        pend[pend.size() - 1].last = 1'b1;
    endfunction

    function automatic void load_front();
        uop_t e;
        e      = pend.pop_front();
        m_v    = 1'b1;
        m_op   = e.op;
        m_uop  = e.uop;
        m_last = e.last;
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_v      = 1'b0;
        m_op     = 7'd0;
        m_uop    = 2'd0;
        m_last   = 1'b0;
        m_ack    = 1'b0;
        m_halted = 1'b0;
        m_ipend  = 1'b0;
    endfunction

    function automatic logic model_fready(input logic dr);
        return !m_halted && (pend.size() == 0) && (!m_v || dr) && !m_ipend;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic void model_step(input logic fv, input logic [6:0] op,
                                       input logic ir, input logic dr);
        logic free;
        logic fr;
        logic started;
        free    = !m_v || dr;
        fr      = model_fready(dr);
        started = 1'b0;
        m_ack   = 1'b0;
        if (free) begin
            if (pend.size() != 0) begin
                load_front();
            end else if (m_ipend) begin
                expand(2'b10, 2'b00);
                load_front();
                m_ack    = 1'b1;
                m_halted = 1'b0;
                started  = 1'b1;
            end else if (fv && fr) begin
                if (op[6:4] == 3'b111) begin
                    expand(op[3:2], op[1:0]);
                    load_front();
                end else begin
                    m_v    = 1'b1;
                    m_op   = op;
                    m_uop  = 2'b00;
                    m_last = 1'b1;
                    if (op[6:2] == 5'b00001) m_halted = 1'b1;
                end
            end else begin
                m_v = 1'b0;
            end
        end
        m_ipend = ir || (m_ipend && !started);
    endfunction

    // Check outputs against the model, apply inputs, advance one edge.
    task automatic tick(input logic fv, input logic [6:0] op, input logic ir, input logic dr);
        @(negedge clk);
        chk("d_valid", 32'(bus.d_valid), 32'(m_v));
        if (m_v) begin
            chk("d_opcode", 32'(bus.d_opcode), 32'(m_op));
            chk("d_uop", 32'(bus.d_uop), 32'(m_uop));
            chk("d_last", 32'(bus.d_last), 32'(m_last));
        end
        chk("int_ack", 32'(bus.int_ack), 32'(m_ack));
        chk("halted", 32'(bus.halted), 32'(m_halted));
        bus.f_valid  = fv;
        bus.f_opcode = op;
        bus.int_req  = ir;
        bus.d_ready  = dr;
        #1;
        chk("f_ready", 32'(bus.f_ready), 32'(model_fready(dr)));
        @(posedge clk);
        model_step(fv, op, ir, dr);
    endtask

    task automatic expect_uop(input string tag, input logic [6:0] op, input logic [1:0] u,
                              input logic last);
        #1;
        chk({tag, "_valid"}, 32'(bus.d_valid), 32'd1);
        chk({tag, "_op"}, 32'(bus.d_opcode), 32'(op));
        chk({tag, "_uop"}, 32'(bus.d_uop), 32'(u));
        chk({tag, "_last"}, 32'(bus.d_last), 32'(last));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.f_valid  = 1'b0;
        bus.f_opcode = 7'd0;
        bus.int_req  = 1'b0;
        bus.d_ready  = 1'b1;
        model_reset();
        #12;
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_d_opcode", 32'(bus.d_opcode), 32'd0);
        chk("rst_d_uop", 32'(bus.d_uop), 32'd0);
        chk("rst_d_last", 32'(bus.d_last), 32'd0);
        chk("rst_int_ack", 32'(bus.int_ack), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back plain opcodes at full rate.
        tick(1'b1, ADD, 1'b0, 1'b1);
        expect_uop("add", ADD, 2'b00, 1'b1);
        tick(1'b1, SUB, 1'b0, 1'b1);
        expect_uop("sub", SUB, 2'b00, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);

        // CALL ab=01.
        tick(1'b1, 7'b1110001, 1'b0, 1'b1);
        expect_uop("call0", PUSH, 2'b01, 1'b0);
        chk("call_f_ready", 32'(bus.f_ready), 32'd0);
        tick(1'b1, ADD, 1'b0, 1'b1);
        expect_uop("call1", 7'b1101101, 2'b00, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);

        // RTI with a three-cycle stall after the first POP.
        tick(1'b1, 7'b1111100, 1'b0, 1'b1);
        expect_uop("rti0", POP, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, NOP, 1'b0, 1'b0);
            expect_uop("rti_hold", POP, 2'b10, 1'b0);
        end
        tick(1'b0, NOP, 1'b0, 1'b1);
        expect_uop("rti1", POP, 2'b01, 1'b0);
        tick(1'b0, NOP, 1'b0, 1'b1);
        expect_uop("rti2", NOP, 2'b00, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);
        #1 chk("rti_done", 32'(bus.d_valid), 32'd0);

        // HLT parks the front end until an interrupt.
        tick(1'b1, HLT, 1'b0, 1'b1);
        expect_uop("hlt", HLT, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, ADD, 1'b0, 1'b1);
            #1;
            chk("hlt_halted", 32'(bus.halted), 32'd1);
            chk("hlt_f_ready", 32'(bus.f_ready), 32'd0);
        end
        tick(1'b0, NOP, 1'b1, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);
        #1 chk("hlt_int_ack", 32'(bus.int_ack), 32'd1);
        chk("hlt_unhalt", 32'(bus.halted), 32'd0);
        expect_uop("hlt_irq0", PUSH, 2'b01, 1'b0);
        tick(1'b0, NOP, 1'b0, 1'b1);
        expect_uop("hlt_irq1", PUSH, 2'b10, 1'b0);
        tick(1'b0, NOP, 1'b0, 1'b1);
        expect_uop("hlt_irq2", 7'b1101100, 2'b11, 1'b1);

        // Interrupt during CALL step 0 waits for CALL to finish.
        tick(1'b1, 7'b1110010, 1'b0, 1'b1);
        expect_uop("ccall0", PUSH, 2'b01, 1'b0);
        tick(1'b1, ADD, 1'b1, 1'b1);
        expect_uop("ccall1", 7'b1101110, 2'b00, 1'b1);
        chk("cint_f_ready0", 32'(bus.f_ready), 32'd0);
        tick(1'b1, ADD, 1'b0, 1'b1);
        #1 chk("cint_ack", 32'(bus.int_ack), 32'd1);
        expect_uop("cint0", PUSH, 2'b01, 1'b0);
        tick(1'b1, ADD, 1'b0, 1'b1);
        expect_uop("cint1", PUSH, 2'b10, 1'b0);
        chk("cint_f_ready1", 32'(bus.f_ready), 32'd0);
        tick(1'b1, ADD, 1'b0, 1'b1);
        expect_uop("cint2", 7'b1101100, 2'b11, 1'b1);
        tick(1'b1, ADD, 1'b0, 1'b1);
        expect_uop("cadd", ADD, 2'b00, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);

        // Reset during INT step 1 clears outputs immediately.
        tick(1'b0, NOP, 1'b1, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);
        tick(1'b0, NOP, 1'b1, 1'b1);
        expect_uop("rint1", PUSH, 2'b10, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("mrst_d_opcode", 32'(bus.d_opcode), 32'd0);
        chk("mrst_d_uop", 32'(bus.d_uop), 32'd0);
        bus.int_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b1, NOP, 1'b0, 1'b1);
        expect_uop("post_rst_nop", NOP, 2'b00, 1'b1);
        tick(1'b0, NOP, 1'b0, 1'b1);
        #1 chk("post_rst_idle", 32'(bus.d_valid), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic       fv;
            logic [6:0] op;
            logic       ir;
            logic       dr;
            fv = ($urandom % 4) != 0;
            op = 7'($urandom);
            ir = ($urandom % 30) == 0;
            dr = ($urandom % 4) != 0;
            tick(fv, op, ir, dr);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, NOP, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
